reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
Shares the register file's single write port among NUM_REQ writeback requesters, for example ALU result, load return and debug/host poke.
- Per-requester valid/ready handshake; round-robin grant; registered drive of wr_en / wr_reg_index / wr_reg_data into the register file.
- Discards writes to register 0 at the port, so the hardwired-zero register never sees wr_en.
- Keeps committed-write and dropped-write counters for debug.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8).
REG_INDEX_WIDTH, 5, register index width.
REGISTER_WIDTH, 32, register data width.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
req_valid  input  NUM_REQ  bit i set: requester i presents a write.
req_index  input  NUM_REQ*REG_INDEX_WIDTH  packed target indices; requester i occupies slice [i*REG_INDEX_WIDTH +: REG_INDEX_WIDTH].
req_data  input  NUM_REQ*REGISTER_WIDTH  packed write data, same slicing.
req_ready  output  NUM_REQ  one-hot (or zero) grant; a transfer occurs on a cycle where valid&ready.
wr_en  output  1  write enable to the register file.
wr_reg_index  output  REG_INDEX_WIDTH  register file write index.
wr_reg_data  output  REGISTER_WIDTH  register file write data.
grant_id  output  3  index of the requester whose write is currently on wr_* (valid when wr_en=1).
wr_count  output  CNT_WIDTH  committed writes (wr_en pulses), saturating.
drop_count  output  CNT_WIDTH  accepted writes to index 0 that were discarded, saturating.

Behaviour:
Reset:
- rst=1 forces wr_en=0, wr_reg_index=0, wr_reg_data=0, grant_id=0, wr_count=0, drop_count=0 and rr_ptr=0, asynchronously.
- req_ready=0 while rst=1.
- Reset mid-transfer discards any accepted but not-yet-driven write. No wr_en pulse occurs after rst deasserts unless there is a new handshake.

Arbitration (combinational, each cycle):
- Scan requesters starting at rr_ptr, upward with wrap modulo NUM_REQ.
- The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
- If no requester is valid, req_ready=0.
- req_ready depends only on req_valid and rr_ptr, never on req_index or req_data.

Requester rule:
- Once valid is asserted, it stays asserted with index and data stable until the handshake.
- Deasserting valid before ready is illegal. The arbiter does not check for it.

Pointer update:
- On a handshake by requester g, rr_ptr <= (g+1) mod NUM_REQ at the next edge.
- With no handshake, rr_ptr holds.
- Guarantees: each continuously valid requester is granted within NUM_REQ cycles. One grant per cycle, so sustained throughput is 1 write/cycle.

Output stage (registered, latency 1):
- A handshake in cycle N with index != 0: in cycle N+1, wr_en=1, wr_reg_index and wr_reg_data equal the accepted values, grant_id=g. wr_count increments, holding at its maximum value once it gets there.
- A handshake in cycle N with index == 0: in cycle N+1, wr_en=0 and drop_count increments (saturating). wr_reg_index and wr_reg_data hold their previous values.
- No handshake in cycle N: wr_en=0 in N+1, and wr_reg_index, wr_reg_data and grant_id hold their previous values.
- wr_en is never asserted for two different writes in one cycle. Back-to-back handshakes give wr_en high on consecutive cycles with the new data each cycle.

Simultaneous events:
- All NUM_REQ valid in the same cycle: grants go in rr_ptr order, one per cycle.
- The register file's write lands on the clk edge ending cycle N+1, so the data is readable from cycle N+2.
- The arbiter does not forward data; the consumer is responsible.

Test Plan:
- Reset: assert rst mid-cycle with req_valid=3'b111 -> wr_en, req_ready, wr_count, drop_count and grant_id are 0 immediately. After release, the first grant goes to requester 0.
- Single write: req0 index 5, data 1234, valid one cycle -> req_ready[0]=1 that cycle; next cycle wr_en=1, wr_reg_index=5, wr_reg_data=1234, grant_id=0, wr_count=1; reg_data_1 reads 1234 at index 5 afterwards.
- Round-robin: all three valid continuously with indices 1, 2, 3 and data 10, 20, 30 -> grants 0, 1, 2, 0, ... The wr_* sequence is (1,10), (2,20), (3,30), (1,10) on consecutive cycles, wr_en held high.
- Fairness: req0 valid continuously; req2 raises valid while rr_ptr=1 -> req2 is granted next cycle, before req0 is granted again.
- Register 0 drop: req1 index 0, data 2431 -> handshake completes, wr_en stays 0, drop_count=1, and register 0 still reads 0.
- Saturation: force or preload wr_count to 16'hFFFF, then perform one more write -> wr_count stays 16'hFFFF.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Writes to register 0 are dropped at the port; committed/dropped writes are counted.
module reg_wb_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int REG_INDEX_WIDTH = 5,
    parameter int REGISTER_WIDTH  = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*REG_INDEX_WIDTH-1:0]   req_index,
    input  logic [NUM_REQ*REGISTER_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 wr_en,
    output logic [REG_INDEX_WIDTH-1:0]           wr_reg_index,
    output logic [REGISTER_WIDTH-1:0]            wr_reg_data,
    output logic [2:0]                           grant_id,
    output logic [CNT_WIDTH-1:0]                 wr_count,
    output logic [CNT_WIDTH-1:0]                 drop_count
);

    logic [2:0]                 rr_ptr_q, rr_ptr_d;
    logic                       wr_en_q;
    logic [REG_INDEX_WIDTH-1:0] wr_idx_q;
    logic [REGISTER_WIDTH-1:0]  wr_data_q;
    logic [2:0]                 gid_q;
    logic [CNT_WIDTH-1:0]       wr_cnt_q, drop_cnt_q;

    logic                       gnt_vld;
    logic [2:0]                 gnt_sel;
    logic [REG_INDEX_WIDTH-1:0] sel_idx;
    logic [REGISTER_WIDTH-1:0]  sel_data;

    // Two passes give the wrap-around scan: first the requesters at or above
    // rr_ptr, then those below it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_vld && req_valid[j] && (3'(j) >= rr_ptr_q)) begin
                gnt_vld = 1'b1;
                gnt_sel = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_vld && req_valid[j] && (3'(j) < rr_ptr_q)) begin
                gnt_vld = 1'b1;
                gnt_sel = 3'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_idx   = '0;
        sel_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_sel == 3'(j)) begin
                req_ready[j] = gnt_vld && !rst;
                sel_idx      = req_index[j*REG_INDEX_WIDTH +: REG_INDEX_WIDTH];
                sel_data     = req_data[j*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
        rr_ptr_d = (gnt_sel == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_sel + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            gid_q      <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (gnt_vld) begin
                rr_ptr_q <= rr_ptr_d;
                if (sel_idx != '0) begin
                    wr_en_q   <= 1'b1;
                    wr_idx_q  <= sel_idx;
                    wr_data_q <= sel_data;
                    gid_q     <= gnt_sel;
                    if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
                end else if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_reg_index = wr_idx_q;
    assign wr_reg_data  = wr_data_q;
    assign grant_id     = gid_q;
    assign wr_count     = wr_cnt_q;
    assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, single write, round-robin, fairness,
// register-0 drop, mid-transfer reset and counter saturation (8-bit counters).
module tb_reg_wb_arbiter;
    localparam int N   = 3;
    localparam int IW  = 5;
    localparam int DW  = 32;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*IW-1:0]   req_index;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              wr_en;
    logic [IW-1:0]     wr_reg_index;
    logic [DW-1:0]     wr_reg_data;
    logic [2:0]        grant_id;
    logic [CW-1:0]     wr_count;
    logic [CW-1:0]     drop_count;
    logic [DW-1:0]     rf [32];

    int n_cmp = 0;
    int n_err = 0;

    reg_wb_arbiter #(.NUM_REQ(N), .REG_INDEX_WIDTH(IW), .REGISTER_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_reg_index(wr_reg_index), .wr_reg_data(wr_reg_data),
        .grant_id(grant_id), .wr_count(wr_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Register file consumer; register 0 never writable.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_en && wr_reg_index != 0) begin
            rf[wr_reg_index] <= wr_reg_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] idx, input logic [DW-1:0] dat);
        req_index[i*IW +: IW] = idx;
        req_data[i*DW +: DW]  = dat;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_index = '0; req_data = '0;
        tick; tick;
        rst = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_index", wr_reg_index, 0);
        chk("rst_data", wr_reg_data, 0);

        // Single write from requester 0
        set_req(0, 5'd5, 32'd1234); req_valid = 3'b001;
        #1 chk("single_ready", req_ready, 3'b001);
        tick; req_valid = '0;
        chk("single_wr_en", wr_en, 1);
        chk("single_index", wr_reg_index, 5);
        chk("single_data", wr_reg_data, 1234);
        chk("single_gid", grant_id, 0);
        chk("single_count", wr_count, 1);
        tick;
        chk("single_idle_wr_en", wr_en, 0);
        chk("single_hold_index", wr_reg_index, 5);
        chk("single_rf5", rf[5], 1234);

        // rr_ptr=1: requester 2 alone gets it and moves the pointer to 0
        set_req(2, 5'd7, 32'd77); req_valid = 3'b100;
        #1 chk("wrap_ready", req_ready, 3'b100);
        tick; req_valid = '0;
        chk("wrap_gid", grant_id, 2);
        chk("wrap_count", wr_count, 2);

        // Round-robin with all three valid
        set_req(0, 5'd1, 32'd10); set_req(1, 5'd2, 32'd20); set_req(2, 5'd3, 32'd30);
        req_valid = 3'b111;
        #1 chk("rr_ready0", req_ready, 3'b001);
        tick;
        chk("rr1_idx", wr_reg_index, 1); chk("rr1_data", wr_reg_data, 10); chk("rr1_gid", grant_id, 0);
        chk("rr1_ready", req_ready, 3'b010);
        tick;
        chk("rr2_en", wr_en, 1); chk("rr2_idx", wr_reg_index, 2); chk("rr2_data", wr_reg_data, 20);
        chk("rr2_gid", grant_id, 1); chk("rr2_ready", req_ready, 3'b100);
        tick;
        chk("rr3_en", wr_en, 1); chk("rr3_idx", wr_reg_index, 3); chk("rr3_data", wr_reg_data, 30);
        chk("rr3_gid", grant_id, 2); chk("rr3_ready", req_ready, 3'b001);
        tick;
        req_valid = '0;
        chk("rr4_en", wr_en, 1); chk("rr4_idx", wr_reg_index, 1); chk("rr4_data", wr_reg_data, 10);
        chk("rr4_gid", grant_id, 0);
        tick;
        chk("rr_idle_en", wr_en, 0);
        chk("rr_count", wr_count, 6);

        // Fairness: req0 continuous, req2 joins while rr_ptr=1
        set_req(0, 5'd4, 32'd40); set_req(2, 5'd6, 32'd60);
        req_valid = 3'b001;
        #1 chk("fair_ready0", req_ready, 3'b001);
        tick;
        req_valid = 3'b101;
        #1 chk("fair_ready2", req_ready, 3'b100);
        tick;
        req_valid = 3'b001;
        chk("fair_gid2", grant_id, 2); chk("fair_idx6", wr_reg_index, 6);
        chk("fair_ready_back0", req_ready, 3'b001);
        tick;
        req_valid = '0;
        chk("fair_gid0", grant_id, 0); chk("fair_data40", wr_reg_data, 40);
        tick;
        chk("fair_count", wr_count, 9);

        // Register 0 drop from requester 1 (rr_ptr=1)
        set_req(1, 5'd0, 32'd2431); req_valid = 3'b010;
        #1 chk("drop_ready", req_ready, 3'b010);
        tick; req_valid = '0;
        chk("drop_wr_en", wr_en, 0);
        chk("drop_count1", drop_count, 1);
        chk("drop_hold_idx", wr_reg_index, 4);
        chk("drop_hold_data", wr_reg_data, 40);
        chk("drop_wr_count", wr_count, 9);
        tick;
        chk("drop_rf0", rf[0], 0);

        // Reset mid-cycle with all valid (rr_ptr=2)
        set_req(0, 5'd9, 32'd90); set_req(1, 5'd10, 32'd100); set_req(2, 5'd11, 32'd110);
        req_valid = 3'b111;
        tick;
        chk("pre_rst_idx", wr_reg_index, 11);
        #2 rst = 1'b1;
        #1;
        chk("mrst_wr_en", wr_en, 0); chk("mrst_ready", req_ready, 0);
        chk("mrst_wr_count", wr_count, 0); chk("mrst_drop", drop_count, 0);
        chk("mrst_gid", grant_id, 0); chk("mrst_idx", wr_reg_index, 0);
        tick;
        #2 rst = 1'b0;
        #1 chk("post_rst_ready", req_ready, 3'b001);
        chk("post_rst_wr_en", wr_en, 0);
        tick;
        req_valid = '0;
        chk("post_rst_gid", grant_id, 0); chk("post_rst_idx", wr_reg_index, 9);
        chk("post_rst_count", wr_count, 1);
        tick;
        chk("post_rst_idle", wr_en, 0);

        // wr_count saturation: 254 more writes reach 8'hFF, one more holds it
        set_req(0, 5'd1, 32'd5); req_valid = 3'b001;
        for (int i = 0; i < 254; i++) tick;
        chk("sat_reach", wr_count, 8'hFF);
        tick;
        req_valid = '0;
        chk("sat_hold_en", wr_en, 1);
        chk("sat_hold", wr_count, 8'hFF);

        // drop_count saturation
        set_req(0, 5'd0, 32'd3); req_valid = 3'b001;
        for (int i = 0; i < 255; i++) tick;
        chk("dsat_reach", drop_count, 8'hFF);
        tick;
        req_valid = '0;
        chk("dsat_hold", drop_count, 8'hFF);
        chk("dsat_no_en", wr_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
